// File: rtl/icache_linefill_collector_pkg.sv
// Shared types and default sizes for the icache linefill collector.
// Provides the beat/line/index widths, the assembled-line record and the
// per-buffer state encoding used by the collector and its line buffers.
package icache_linefill_collector_pkg;

  localparam int ICACHE_LINE_BEATS      = 4;
  localparam int ICACHE_BEAT_WIDTH      = 128;
  localparam int MSHR_ENTRY_INDEX_WIDTH = 2;
  localparam int ICACHE_LINE_WIDTH      = ICACHE_BEAT_WIDTH * ICACHE_LINE_BEATS;

  typedef struct packed {
    logic [ICACHE_LINE_WIDTH-1:0]      data;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_idx;
  } linefill_t;

  typedef enum logic [1:0] {
    LB_EMPTY   = 2'd0,
    LB_FILLING = 2'd1,
    LB_FULL    = 2'd2
  } lbuf_state_e;

endpackage

// File: rtl/icache_linefill_collector_if.sv
// Bus bundle for the icache linefill collector.
// Carries the rxdat beat channel (vld/rdy/data/entry_idx/last), the linefill
// line channel (vld/rdy/data/entry_idx) and the done/error pulses.
// slave  : collector side (consumes rxdat, produces linefill and pulses)
// master : environment side (produces rxdat, consumes linefill and pulses)
interface icache_linefill_collector_if
  import icache_linefill_collector_pkg::*;
#(
  parameter int BEAT_WIDTH     = ICACHE_BEAT_WIDTH,
  parameter int LINE_BEATS     = ICACHE_LINE_BEATS,
  parameter int MSHR_IDX_WIDTH = MSHR_ENTRY_INDEX_WIDTH
);
  logic                             rxdat_vld;
  logic                             rxdat_rdy;
  logic [BEAT_WIDTH-1:0]            rxdat_data;
  logic [MSHR_IDX_WIDTH-1:0]        rxdat_entry_idx;
  logic                             rxdat_last;
  logic                             linefill_vld;
  logic                             linefill_rdy;
  logic [BEAT_WIDTH*LINE_BEATS-1:0] linefill_data;
  logic [MSHR_IDX_WIDTH-1:0]        linefill_entry_idx;
  logic                             linefill_done;
  logic [MSHR_IDX_WIDTH-1:0]        linefill_done_idx;
  logic                             protocol_err;

  modport slave (
    input  rxdat_vld, rxdat_data, rxdat_entry_idx, rxdat_last, linefill_rdy,
    output rxdat_rdy, linefill_vld, linefill_data, linefill_entry_idx,
           linefill_done, linefill_done_idx, protocol_err
  );

  modport master (
    output rxdat_vld, rxdat_data, rxdat_entry_idx, rxdat_last, linefill_rdy,
    input  rxdat_rdy, linefill_vld, linefill_data, linefill_entry_idx,
           linefill_done, linefill_done_idx, protocol_err
  );
endinterface

// File: rtl/icache_linefill_collector_lbuf.sv
// One ping-pong line buffer: beat slots, owning MSHR index and fill state.
// Ports:
//   clk, rst_n            clock, async active-low reset (state only)
//   beat_wr/beat_slot/beat_data   write one beat into a slot
//   idx_wr/idx_in         capture the owning MSHR index (first beat)
//   fill_done             line completed -> FULL
//   fill_abort            malformed line -> EMPTY
//   drain                 line handed to the data array -> EMPTY
//   state/line_data/line_idx      buffer status and contents
module icache_linefill_lbuf
  import icache_linefill_collector_pkg::*;
#(
  parameter int BEAT_WIDTH     = ICACHE_BEAT_WIDTH,
  parameter int LINE_BEATS     = ICACHE_LINE_BEATS,
  parameter int MSHR_IDX_WIDTH = MSHR_ENTRY_INDEX_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             beat_wr,
  input  logic [$clog2(LINE_BEATS)-1:0]    beat_slot,
  input  logic [BEAT_WIDTH-1:0]            beat_data,
  input  logic                             idx_wr,
  input  logic [MSHR_IDX_WIDTH-1:0]        idx_in,
  input  logic                             fill_done,
  input  logic                             fill_abort,
  input  logic                             drain,
  output lbuf_state_e                      state,
  output logic [BEAT_WIDTH*LINE_BEATS-1:0] line_data,
  output logic [MSHR_IDX_WIDTH-1:0]        line_idx
);
  lbuf_state_e                             state_nxt;
  logic [LINE_BEATS-1:0][BEAT_WIDTH-1:0]   slots;
  logic [MSHR_IDX_WIDTH-1:0]               idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LB_EMPTY;
    else        state <= state_nxt;
  end

  // Abort wins over completion: a beat flagged as malformed never fills the line.
  always_comb begin
    state_nxt = state;
    case (state)
      LB_EMPTY, LB_FILLING: begin
        if (fill_abort)     state_nxt = LB_EMPTY;
        else if (fill_done) state_nxt = LB_FULL;
        else if (beat_wr)   state_nxt = LB_FILLING;
      end
      LB_FULL: begin
        if (drain) state_nxt = LB_EMPTY;
      end
      default: state_nxt = LB_EMPTY;
    endcase
  end

  // Payload storage carries no reset; the collector masks it while not valid.
  always_ff @(posedge clk) begin
    if (beat_wr) slots[beat_slot] <= beat_data;
    if (idx_wr)  idx_q <= idx_in;
  end

  assign line_data = slots;
  assign line_idx  = idx_q;
endmodule

// File: rtl/icache_linefill_collector.sv
// icache linefill collector: assembles rxdat beats into full cache lines in
// two ping-pong buffers and hands each line to the data array in order.
// Ports:
//   clk    clock
//   rst_n  async active-low reset
//   bus    slave modport: rxdat beat channel in, linefill line channel out,
//          linefill_done/linefill_done_idx retire pulse, protocol_err pulse
module icache_linefill_collector
  import icache_linefill_collector_pkg::*;
#(
  parameter int BEAT_WIDTH     = ICACHE_BEAT_WIDTH,
  parameter int LINE_BEATS     = ICACHE_LINE_BEATS,
  parameter int MSHR_IDX_WIDTH = MSHR_ENTRY_INDEX_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  icache_linefill_collector_if.slave  bus
);
  localparam int                CNT_W     = $clog2(LINE_BEATS);
  localparam int                LINE_W    = BEAT_WIDTH * LINE_BEATS;
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(LINE_BEATS - 1);

  logic                      run_p0;
  logic                      wr_sel;
  logic                      rd_sel;
  logic [CNT_W-1:0]          beat_cnt;
  logic                      done_p1;
  logic [MSHR_IDX_WIDTH-1:0] done_idx_p1;
  logic                      err_p1;

  lbuf_state_e               lb_state [2];
  logic [LINE_W-1:0]         lb_data  [2];
  logic [MSHR_IDX_WIDTH-1:0] lb_idx   [2];

  logic [1:0] beat_wr, idx_wr, fill_done, fill_abort, drain;
  logic       rx_rdy, accept, last_slot, idx_bad, beat_err, line_ok;
  logic       lf_vld, handshake;

  for (genvar b = 0; b < 2; b++) begin : g_lbuf
    icache_linefill_lbuf #(
      .BEAT_WIDTH     (BEAT_WIDTH),
      .LINE_BEATS     (LINE_BEATS),
      .MSHR_IDX_WIDTH (MSHR_IDX_WIDTH)
    ) u_lbuf (
      .clk        (clk),
      .rst_n      (rst_n),
      .beat_wr    (beat_wr[b]),
      .beat_slot  (beat_cnt),
      .beat_data  (bus.rxdat_data),
      .idx_wr     (idx_wr[b]),
      .idx_in     (bus.rxdat_entry_idx),
      .fill_done  (fill_done[b]),
      .fill_abort (fill_abort[b]),
      .drain      (drain[b]),
      .state      (lb_state[b]),
      .line_data  (lb_data[b]),
      .line_idx   (lb_idx[b])
    );
  end

  // Accept/check stage: classify the incoming beat against the line in progress.
  // rdy depends on registered state only, so there is no path from linefill_rdy.
  always_comb begin
    rx_rdy     = run_p0 && (lb_state[wr_sel] != LB_FULL);
    accept     = bus.rxdat_vld && rx_rdy;
    last_slot  = (beat_cnt == LAST_SLOT);
    // The captured index is only meaningful once the first beat has landed.
    idx_bad    = (beat_cnt != '0) && (bus.rxdat_entry_idx != lb_idx[wr_sel]);
    beat_err   = (bus.rxdat_last != last_slot) || idx_bad;
    line_ok    = !beat_err && last_slot;
    lf_vld     = (lb_state[rd_sel] == LB_FULL);
    handshake  = lf_vld && bus.linefill_rdy;

    beat_wr    = '0;
    idx_wr     = '0;
    fill_done  = '0;
    fill_abort = '0;
    drain      = '0;
    beat_wr[wr_sel]    = accept;
    idx_wr[wr_sel]     = accept && (beat_cnt == '0);
    fill_done[wr_sel]  = accept && line_ok;
    fill_abort[wr_sel] = accept && beat_err;
    drain[rd_sel]      = handshake;
  end

  // Control registers: buffer selectors, beat counter and one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_p0      <= 1'b0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      beat_cnt    <= '0;
      done_p1     <= 1'b0;
      done_idx_p1 <= '0;
      err_p1      <= 1'b0;
    end else begin
      run_p0  <= 1'b1;
      done_p1 <= handshake;
      err_p1  <= accept && beat_err;
      if (accept) begin
        beat_cnt <= beat_err ? '0 : CNT_W'(beat_cnt + 1'b1);
        if (line_ok) wr_sel <= ~wr_sel;
      end
      if (handshake) begin
        rd_sel      <= ~rd_sel;
        done_idx_p1 <= lb_idx[rd_sel];
      end
    end
  end

  assign bus.rxdat_rdy          = rx_rdy;
  assign bus.linefill_vld       = lf_vld;
  assign bus.linefill_data      = lf_vld ? lb_data[rd_sel] : '0;
  assign bus.linefill_entry_idx = lf_vld ? lb_idx[rd_sel]  : '0;
  assign bus.linefill_done      = done_p1;
  assign bus.linefill_done_idx  = done_idx_p1;
  assign bus.protocol_err       = err_p1;
endmodule
